pong_score_keeper: RTL and testbench

Match-control stage directly upstream of the OLED score display in the pong design. It receives single-cycle point strobes from the ball/paddle logic and keeps both players' scores. It gates ball motion through a serve delay after each point and detects the end of a match. The 4-bit scores feed the display's score1/score2 inputs directly; score_update tells the display wrapper when to refresh.

---
 rtl/pong_score_keeper.sv | 116 +++++++++++
 tb/tb_pong_score_keeper.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
// Match control for pong: keeps both scores, holds the ball through a serve
// delay after each point, and detects the end of a match.
module pong_score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       serve_en,
  output logic       serve_dir,
  output logic       score_update,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       score1_inc;
  logic [3:0]       score2_inc;

  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      score1       <= 4'd0;
      score2       <= 4'd0;
      serve_en     <= 1'b0;
      serve_dir    <= 1'b0;
      score_update <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
    end else begin
      score_update <= 1'b0;
      // start restarts the match from any state and outranks point strobes
      if (start) begin
        state        <= SERVE;
        cnt          <= '0;
        score1       <= 4'd0;
        score2       <= 4'd0;
        serve_en     <= 1'b0;
        serve_dir    <= 1'b0;
        score_update <= 1'b1;
        game_over    <= 1'b0;
        winner       <= 2'b00;
      end else begin
        case (state)
          IDLE: begin
            serve_en <= 1'b0;
          end
          SERVE: begin
            serve_en <= 1'b0;
            if (cnt == CNT_LAST) begin
              state <= PLAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PLAY: begin
            serve_en <= 1'b1;
            // simultaneous strobes cancel out; only a lone strobe scores
            if (p1_point && !p2_point) begin
              score1       <= score1_inc;
              score_update <= 1'b1;
              serve_en     <= 1'b0;
              serve_dir    <= 1'b1;
              if (score1_inc == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 2'b01;
              end else begin
                state <= SERVE;
                cnt   <= '0;
              end
            end else if (p2_point && !p1_point) begin
              score2       <= score2_inc;
              score_update <= 1'b1;
              serve_en     <= 1'b0;
              serve_dir    <= 1'b0;
              if (score2_inc == WIN) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= 2'b10;
              end else begin
                state <= SERVE;
                cnt   <= '0;
              end
            end
          end
          OVER: begin
            serve_en  <= 1'b0;
            game_over <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            serve_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with WIN_SCORE=3, SERVE_DELAY=4.
module tb_pong_score_keeper;

  localparam int WIN_SCORE   = 3;
  localparam int SERVE_DELAY = 4;

  logic       clk = 1'b0;
  logic       rst, start, p1_point, p2_point;
  logic [3:0] score1, score2;
  logic       serve_en, serve_dir, score_update, game_over;
  logic [1:0] winner;
  logic [13:0] got;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        st;
    logic        p1;
    logic        p2;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  pong_score_keeper #(.WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY)) dut (
    .clk(clk), .rst(rst), .start(start), .p1_point(p1_point), .p2_point(p2_point),
    .score1(score1), .score2(score2), .serve_en(serve_en), .serve_dir(serve_dir),
    .score_update(score_update), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  assign got = {score1, score2, serve_en, serve_dir, score_update, game_over, winner};

  function automatic logic [13:0] ev(input logic [3:0] s1, input logic [3:0] s2,
                                     input logic en, input logic dir, input logic upd,
                                     input logic go, input logic [1:0] win);
    return {s1, s2, en, dir, upd, go, win};
  endfunction

  task automatic add(input logic st, input logic p1, input logic p2,
                     input logic [3:0] s1, input logic [3:0] s2, input logic en,
                     input logic dir, input logic upd, input logic go, input logic [1:0] win);
    vec_t v;
    v.st = st; v.p1 = p1; v.p2 = p2;
    v.exp = ev(s1, s2, en, dir, upd, go, win);
    tbl.push_back(v);
  endtask

  // Four held cycles after entering SERVE, then the cycle serve_en rises.
  // poke drives a p1 strobe during the first held cycle; it must be ignored.
  task automatic serve_wait(input logic [3:0] s1, input logic [3:0] s2, input logic dir,
                            input logic poke);
    for (int i = 0; i < SERVE_DELAY; i++)
      add(1'b0, (i == 0) && poke, 1'b0, s1, s2, 1'b0, dir, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b0, s1, s2, 1'b1, dir, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic drive(input logic r, input logic st, input logic a, input logic b);
    @(negedge clk);
    rst = r; start = st; p1_point = a; p2_point = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {s1,s2,en,dir,upd,go,win}=%b want %b", name, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; p1_point = 1'b1; p2_point = 1'b0;

    // reset with start and p1 held high
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("reset", ev(0, 0, 0, 0, 0, 0, 2'b00));

    // start, then a p1 point, then p2 wins 3-1
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    serve_wait(0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00);
    serve_wait(1, 0, 1, 0);
    add(0, 0, 1, 1, 1, 0, 0, 1, 0, 2'b00);
    serve_wait(1, 1, 0, 1);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00);
    add(0, 0, 1, 1, 2, 0, 0, 1, 0, 2'b00);
    serve_wait(1, 2, 0, 0);
    add(0, 0, 1, 1, 3, 0, 0, 1, 1, 2'b10);
    add(0, 1, 0, 1, 3, 0, 0, 0, 1, 2'b10);
    add(0, 0, 0, 1, 3, 0, 0, 0, 1, 2'b10);
    // restart from OVER, then p1 wins 3-0
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    serve_wait(0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00);
    serve_wait(1, 0, 1, 0);
    add(0, 1, 0, 2, 0, 0, 1, 1, 0, 2'b00);
    serve_wait(2, 0, 1, 0);
    add(0, 1, 0, 3, 0, 0, 1, 1, 1, 2'b01);
    add(0, 0, 1, 3, 0, 0, 1, 0, 1, 2'b01);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    serve_wait(0, 0, 0, 0);
    // start beats a same-cycle point in PLAY
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b0, tbl[i].st, tbl[i].p1, tbl[i].p2);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // rst in the middle of a serve after a point: no pulse, scores cleared
    for (int i = 0; i < SERVE_DELAY; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("play_again", ev(0, 0, 1, 0, 0, 0, 2'b00));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("p2_point", ev(0, 1, 0, 0, 1, 0, 2'b00));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_mid_serve", ev(0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_hold", ev(0, 0, 0, 0, 0, 0, 2'b00));
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_after_rst", ev(0, 0, 0, 0, 1, 0, 2'b00));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("pulse_one_cycle", ev(0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < SERVE_DELAY; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("serve_after_rst", ev(0, 0, 1, 0, 0, 0, 2'b00));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("p1_point_2", ev(1, 0, 0, 1, 1, 0, 2'b00));
    for (int i = 0; i <= SERVE_DELAY; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("play_before_rst", ev(1, 0, 1, 1, 0, 0, 2'b00));
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_mid_play", ev(0, 0, 0, 0, 0, 0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
